// File: rtl/fp_mul_booth_seq_pkg.sv
// Shared widths, FSM/Booth-digit enums and default sideband layout for the
// iterative radix-4 Booth mantissa multiplier.
package fpu_mul_pkg;

    localparam int FRAC_W = 23;
    localparam int MANT_W = FRAC_W + 1;
    localparam int PROD_W = 2 * MANT_W;
    localparam int N_ITER = (MANT_W + 2) / 2;
    localparam int ACC_W  = PROD_W + 2;
    localparam int CNT_W  = $clog2(N_ITER + 1);
    localparam int TAG_W  = 12;

    typedef enum logic [1:0] {IDLE, CALC, DONE} mul_state_t;

    typedef enum logic [2:0] {ZERO, P1, P2, M1, M2} booth_digit_t;

    typedef struct packed {
        logic       sign;
        logic [2:0] r_mode;
        logic [7:0] exp;
    } fp_tag_t;

endpackage

// File: rtl/fp_mul_booth_seq_if.sv
// Operand/result handshake bundle between the FP multiply front end, the
// Booth mantissa multiplier and the normalization stage.
interface fp_mul_booth_seq_if;
    import fpu_mul_pkg::*;

    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [FRAC_W-1:0] in_frc_x;
    logic              in_hid_x;
    logic [FRAC_W-1:0] in_frc_y;
    logic              in_hid_y;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [PROD_W-1:0] out_prod;
    logic [TAG_W-1:0]  out_tag;
    logic              busy;

    modport slave (
        input  flush, in_valid, in_frc_x, in_hid_x, in_frc_y, in_hid_y, in_tag, out_ready,
        output in_ready, out_valid, out_prod, out_tag, busy
    );

    modport master (
        output flush, in_valid, in_frc_x, in_hid_x, in_frc_y, in_hid_y, in_tag, out_ready,
        input  in_ready, out_valid, out_prod, out_tag, busy
    );

endinterface

// File: rtl/fp_mul_booth_seq_enc.sv
// Radix-4 Booth encoder: 3-bit multiplier window {b[2i+1], b[2i], b[2i-1]}
// to a signed digit in {-2,-1,0,+1,+2}. Purely combinational.
module booth_r4_digit_enc
    import fpu_mul_pkg::*;
(
    input  logic [2:0]   win_i,
    output booth_digit_t digit_o
);

    always_comb begin
        digit_o = ZERO;
        unique case (win_i)
            3'b001, 3'b010: digit_o = P1;
            3'b011:         digit_o = P2;
            3'b100:         digit_o = M2;
            3'b101, 3'b110: digit_o = M1;
            default:        digit_o = ZERO;
        endcase
    end

endmodule

// File: rtl/fp_mul_booth_seq.sv
// Iterative radix-4 Booth mantissa multiplier, one digit per cycle, N_ITER
// cycles accept-to-valid. Define FPMUL_BOOTH_ZERO_SKIP_EN to bypass CALC for zero mantissas.
module fp_mul_booth_seq
    import fpu_mul_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    fp_mul_booth_seq_if.slave  bus
);

    mul_state_t         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [MANT_W+1:0]  mcand_q, mcand_d;
    logic [MANT_W+2:0]  mplr_q, mplr_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [PROD_W-1:0]  prod_q, prod_d;
    logic [TAG_W-1:0]   tag_q, tag_d;

    logic [MANT_W-1:0]  mant_x, mant_y;
    booth_digit_t       digit;
    logic [ACC_W-1:0]   m_ext, pp, pp_sh, acc_sum;

    assign mant_x = {bus.in_hid_x, bus.in_frc_x};
    assign mant_y = {bus.in_hid_y, bus.in_frc_y};

    // The multiplier register shifts right by two each CALC cycle, so the
    // current window always sits in its three LSBs.
    booth_r4_digit_enc u_enc (
        .win_i   (mplr_q[2:0]),
        .digit_o (digit)
    );

    // Two's-complement arithmetic modulo 2^ACC_W; the two guard bits keep the
    // partial sums' sign while the final sum is always non-negative.
    always_comb begin
        m_ext = {{(ACC_W-MANT_W-2){1'b0}}, mcand_q};
        pp    = '0;
        unique case (digit)
            P1:      pp = m_ext;
            P2:      pp = m_ext << 1;
            M1:      pp = -m_ext;
            M2:      pp = -(m_ext << 1);
            default: pp = '0;
        endcase
        pp_sh   = pp << {cnt_q, 1'b0};
        acc_sum = acc_q + pp_sh;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mcand_d = mcand_q;
        mplr_d  = mplr_q;
        acc_d   = acc_q;
        prod_d  = prod_q;
        tag_d   = tag_q;

        if (bus.flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        mcand_d = {2'b00, mant_x};
                        mplr_d  = {2'b00, mant_y, 1'b0};
                        tag_d   = bus.in_tag;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = CALC;
`ifdef FPMUL_BOOTH_ZERO_SKIP_EN
                        if ((mant_x == '0) || (mant_y == '0)) begin
                            prod_d  = '0;
                            state_d = DONE;
                        end
`endif
                    end
                end
                CALC: begin
                    acc_d  = acc_sum;
                    mplr_d = {2'b00, mplr_q[MANT_W+2:2]};
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(N_ITER - 1)) begin
                        prod_d  = acc_sum[PROD_W-1:0];
                        state_d = DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mcand_q <= '0;
            mplr_q  <= '0;
            acc_q   <= '0;
            prod_q  <= '0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            mplr_q  <= mplr_d;
            acc_q   <= acc_d;
            prod_q  <= prod_d;
            tag_q   <= tag_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_prod  = prod_q;
    assign bus.out_tag   = tag_q;

endmodule

// File: tb/tb_fp_mul_booth_seq.sv
// Directed vector table plus hand-written backpressure, flush and reset
// sequences for the Booth mantissa multiplier.
module tb_fp_mul_booth_seq;
    import fpu_mul_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    fp_mul_booth_seq_if bus ();

    fp_mul_booth_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edges after the accept edge until out_valid is seen; with zero skip the
    // accept edge itself lands in DONE.
`ifdef FPMUL_BOOTH_ZERO_SKIP_EN
    localparam int ZLAT = 0;
`else
    localparam int ZLAT = 13;
`endif

    typedef struct {
        string             nm;
        logic              hx;
        logic [FRAC_W-1:0] fx;
        logic              hy;
        logic [FRAC_W-1:0] fy;
        logic [TAG_W-1:0]  tag;
        logic [PROD_W-1:0] prod;
        int                lat;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_op(input string nm, input logic hx, input logic [FRAC_W-1:0] fx,
                          input logic hy, input logic [FRAC_W-1:0] fy,
                          input logic [TAG_W-1:0] tag, input logic [PROD_W-1:0] ep,
                          input int elat, input int bp);
        int n;
        bus.in_valid  = 1'b1;
        bus.in_hid_x  = hx;
        bus.in_frc_x  = fx;
        bus.in_hid_y  = hy;
        bus.in_frc_y  = fy;
        bus.in_tag    = tag;
        bus.out_ready = (bp == 0);
        chk({nm, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_tag   = ~tag;
        chk({nm, "_busy"}, 64'(bus.busy), 64'd1);
        chk({nm, "_in_ready_lo"}, 64'(bus.in_ready), 64'd0);
        n = 0;
        while (!bus.out_valid && n < 200) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        chk({nm, "_valid_seen"}, 64'(bus.out_valid), 64'd1);
        chk({nm, "_latency"}, 64'(n), 64'(elat));
        chk({nm, "_prod"}, 64'(bus.out_prod), 64'(ep));
        chk({nm, "_prod47"}, 64'(bus.out_prod[47]), 64'(ep[47]));
        chk({nm, "_tag"}, 64'(bus.out_tag), 64'(tag));
        for (int k = 0; k < bp; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk({nm, "_bp_valid"}, 64'(bus.out_valid), 64'd1);
            chk({nm, "_bp_prod"}, 64'(bus.out_prod), 64'(ep));
            chk({nm, "_bp_tag"}, 64'(bus.out_tag), 64'(tag));
            chk({nm, "_bp_in_ready"}, 64'(bus.in_ready), 64'd0);
            chk({nm, "_bp_busy"}, 64'(bus.busy), 64'd1);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk({nm, "_ret_valid"}, 64'(bus.out_valid), 64'd0);
        chk({nm, "_ret_in_ready"}, 64'(bus.in_ready), 64'd1);
        chk({nm, "_ret_busy"}, 64'(bus.busy), 64'd0);
    endtask

    initial begin
        int seen;
        checks = 0;
        errors = 0;

        vecs[0] = '{"v1p5x1p5", 1'b1, 23'h400000, 1'b1, 23'h400000, 12'hA5C, 48'h900000000000, 13};
        vecs[1] = '{"vmaxfrc",  1'b1, 23'h7FFFFF, 1'b1, 23'h7FFFFF, 12'h123, 48'hFFFFFE000001, 13};
        vecs[2] = '{"vsubx1",   1'b0, 23'h000001, 1'b1, 23'h000000, 12'hFFF, 48'h000000800000, 13};
        vecs[3] = '{"v1x1",     1'b1, 23'h000000, 1'b1, 23'h000000, 12'h800, 48'h400000000000, 13};
        vecs[4] = '{"vmix",     1'b1, 23'h123456, 1'b1, 23'h000000, 12'h0F0, 48'h491A2B000000, 13};
        vecs[5] = '{"valt",     1'b1, 23'h2AAAAA, 1'b1, 23'h000001, 12'h555, 48'h555555AAAAAA, 13};
        vecs[6] = '{"vsub3x3",  1'b0, 23'h000003, 1'b0, 23'h000003, 12'h00F, 48'h000000000009, 13};
        vecs[7] = '{"vzerox",   1'b0, 23'h000000, 1'b1, 23'h400000, 12'h3C3, 48'h000000000000, ZLAT};
        vecs[8] = '{"vzeroy",   1'b1, 23'h400000, 1'b0, 23'h000000, 12'h7E1, 48'h000000000000, ZLAT};

        rst_n         = 1'b0;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_hid_x  = 1'b0;
        bus.in_frc_x  = '0;
        bus.in_hid_y  = 1'b0;
        bus.in_frc_y  = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_out_prod", 64'(bus.out_prod), 64'd0);
        chk("rst_out_tag", 64'(bus.out_tag), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i])
            run_op(vecs[i].nm, vecs[i].hx, vecs[i].fx, vecs[i].hy, vecs[i].fy,
                   vecs[i].tag, vecs[i].prod, vecs[i].lat, 0);

        run_op("bp", 1'b1, 23'h7FFFFF, 1'b1, 23'h400000, 12'hBEE, 48'hBFFFFF400000, 13, 5);

        // Flush lands on the 5th CALC edge; nothing may be presented afterwards.
        bus.in_valid = 1'b1;
        bus.in_hid_x = 1'b1;
        bus.in_frc_x = 23'h7FFFFF;
        bus.in_hid_y = 1'b1;
        bus.in_frc_y = 23'h7FFFFF;
        bus.in_tag   = 12'h111;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.flush = 1'b0;
        chk("flush_valid", 64'(bus.out_valid), 64'd0);
        chk("flush_in_ready", 64'(bus.in_ready), 64'd1);
        chk("flush_busy", 64'(bus.busy), 64'd0);
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        chk("flush_no_valid", 64'(seen), 64'd0);
        run_op("post_flush_3x3", 1'b1, 23'h400000, 1'b1, 23'h400000, 12'h482, 48'h900000000000, 13, 0);

        // Flush beats in_valid in IDLE.
        bus.in_valid = 1'b1;
        bus.flush    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        chk("flush_idle_busy", 64'(bus.busy), 64'd0);
        chk("flush_idle_in_ready", 64'(bus.in_ready), 64'd1);

        // Flush while holding a result in DONE drops it.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (14) @(posedge clk);
        @(negedge clk);
        chk("done_hold_valid", 64'(bus.out_valid), 64'd1);
        bus.flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        chk("flush_done_valid", 64'(bus.out_valid), 64'd0);
        chk("flush_done_busy", 64'(bus.busy), 64'd0);

        // Asynchronous reset mid-CALC.
        bus.in_valid = 1'b1;
        bus.in_hid_x = 1'b1;
        bus.in_frc_x = 23'h400000;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(bus.busy), 64'd0);
        chk("arst_valid", 64'(bus.out_valid), 64'd0);
        chk("arst_prod", 64'(bus.out_prod), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        chk("arst_no_valid", 64'(seen), 64'd0);
        run_op("post_rst_1p5", 1'b1, 23'h400000, 1'b1, 23'h400000, 12'h9A9, 48'h900000000000, 13, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
